// File: rtl/hough_pixel_sequencer.sv
// Scans the lower half of a binary edge frame and feeds set pixels to the Hough voter,
// left ROI then right ROI, latching each ROI's line result.
module hough_pixel_sequencer #(
    parameter int unsigned IMG_W   = 640,
    parameter int unsigned IMG_H   = 480,
    parameter int unsigned ROI_Y0  = 240,
    parameter int unsigned AW      = 19,
    parameter int unsigned RD_LAT  = 2,
    parameter int unsigned RES_LAT = 4
) (
    input  logic          CLK100MHZ,
    input  logic          reset,
    input  logic          start,
    output logic          busy,
    output logic          fb_en,
    output logic [AW-1:0] fb_addr,
    input  logic          fb_dout,
    output logic          ht_reset,
    input  logic          ht_reset_complete,
    output logic [11:0]   ht_x,
    output logic [11:0]   ht_y,
    output logic          ht_pixel,
    output logic          ht_roi,
    output logic          ht_clear,
    output logic          ht_enable,
    input  logic          ht_done,
    input  logic [15:0]   ht_m,
    input  logic [15:0]   ht_b,
    input  logic          ht_lane_dep,
    output logic [15:0]   m_l,
    output logic [15:0]   b_l,
    output logic [15:0]   m_r,
    output logic [15:0]   b_r,
    output logic          ld_l,
    output logic          ld_r,
    output logic          lanes_valid
);

    typedef enum logic [3:0] {
        StIdle, StHrst, StHwait, StFetch, StRead, StClr, StVote, StNext, StRes, StDone
    } state_e;

    localparam logic [11:0]   HALF     = 12'(IMG_W / 2);
    localparam logic [11:0]   LAST_Y   = 12'(IMG_H - ROI_Y0 - 1);
    localparam logic [AW-1:0] ORG_L    = AW'(ROI_Y0 * IMG_W);
    localparam logic [AW-1:0] ORG_R    = AW'(ROI_Y0 * IMG_W + IMG_W / 2);
    // Row wrap skips the other ROI's half row.
    localparam logic [AW-1:0] ROW_SKIP = AW'(IMG_W / 2 + 1);
    localparam logic [7:0]    RD_LAST  = 8'(RD_LAT - 1);
    localparam logic [7:0]    RES_LAST = 8'(RES_LAT - 1);

    state_e        state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [11:0]   x_q, x_d, y_q, y_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          roi_q, roi_d, pix_q, pix_d;
    logic [15:0]   m_l_q, m_l_d, b_l_q, b_l_d, m_r_q, m_r_d, b_r_q, b_r_d;
    logic          ld_l_q, ld_l_d, ld_r_q, ld_r_d;

    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            addr_q  <= '0;
            roi_q   <= 1'b0;
            pix_q   <= 1'b0;
            m_l_q   <= '0;
            b_l_q   <= '0;
            m_r_q   <= '0;
            b_r_q   <= '0;
            ld_l_q  <= 1'b0;
            ld_r_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            addr_q  <= addr_d;
            roi_q   <= roi_d;
            pix_q   <= pix_d;
            m_l_q   <= m_l_d;
            b_l_q   <= b_l_d;
            m_r_q   <= m_r_d;
            b_r_q   <= b_r_d;
            ld_l_q  <= ld_l_d;
            ld_r_q  <= ld_r_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        addr_d  = addr_q;
        roi_d   = roi_q;
        pix_d   = pix_q;
        m_l_d   = m_l_q;
        b_l_d   = b_l_q;
        m_r_d   = m_r_q;
        b_r_d   = b_r_q;
        ld_l_d  = ld_l_q;
        ld_r_d  = ld_r_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StHrst;
                    roi_d   = 1'b0;
                end
            end
            StHrst: begin
                x_d     = '0;
                y_d     = '0;
                addr_d  = roi_q ? ORG_R : ORG_L;
                cnt_d   = '0;
                state_d = StHwait;
            end
            StHwait: begin
                // First cycle ignores a stale completion from the previous clear.
                if (cnt_q == 8'd0) begin
                    cnt_d = 8'd1;
                end else if (ht_reset_complete) begin
                    state_d = StFetch;
                end
            end
            StFetch: begin
                cnt_d   = '0;
                state_d = StRead;
            end
            StRead: begin
                if (cnt_q == RD_LAST) begin
                    pix_d   = fb_dout;
                    state_d = fb_dout ? StClr : StNext;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StClr: state_d = StVote;
            StVote: begin
                if (ht_done) begin
                    state_d = StNext;
                end
            end
            StNext: begin
                pix_d = 1'b0;
                if (x_q == HALF - 12'd1 && y_q == LAST_Y) begin
                    cnt_d   = '0;
                    state_d = StRes;
                end else if (x_q == HALF - 12'd1) begin
                    x_d     = '0;
                    y_d     = y_q + 12'd1;
                    addr_d  = addr_q + ROW_SKIP;
                    state_d = StFetch;
                end else begin
                    x_d     = x_q + 12'd1;
                    addr_d  = addr_q + AW'(1);
                    state_d = StFetch;
                end
            end
            StRes: begin
                if (cnt_q == RES_LAST) begin
                    if (roi_q) begin
                        m_r_d   = ht_m;
                        b_r_d   = ht_b;
                        ld_r_d  = ht_lane_dep;
                        state_d = StDone;
                    end else begin
                        m_l_d   = ht_m;
                        b_l_d   = ht_b;
                        ld_l_d  = ht_lane_dep;
                        roi_d   = 1'b1;
                        state_d = StHrst;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign busy        = (state_q != StIdle);
    assign fb_en       = (state_q == StFetch);
    assign fb_addr     = addr_q;
    assign ht_reset    = (state_q == StHrst);
    assign ht_x        = x_q;
    assign ht_y        = y_q;
    assign ht_pixel    = pix_q;
    assign ht_roi      = roi_q;
    assign ht_clear    = (state_q == StClr);
    assign ht_enable   = (state_q == StVote);
    assign lanes_valid = (state_q == StDone);
    assign m_l         = m_l_q;
    assign b_l         = b_l_q;
    assign m_r         = m_r_q;
    assign b_r         = b_r_q;
    assign ld_l        = ld_l_q;
    assign ld_r        = ld_r_q;

endmodule

// File: tb/tb_hough_pixel_sequencer.sv
// Bench for hough_pixel_sequencer on an 8x4 frame: frame buffer and Hough voter models,
// reference scan list computed from the frame contents.
module tb_hough_pixel_sequencer;

    localparam int W = 8;
    localparam int H = 4;
    localparam int Y0 = 2;

    logic        clk = 1'b0;
    logic        reset, start;
    logic        busy, fb_en, fb_dout, ht_reset, ht_pixel, ht_roi, ht_clear, ht_enable;
    logic [18:0] fb_addr;
    logic [11:0] ht_x, ht_y;
    logic        ht_reset_complete = 1'b0;
    logic        ht_done = 1'b0;
    logic [15:0] ht_m, ht_b, m_l, b_l, m_r, b_r;
    logic        ht_lane_dep, ld_l, ld_r, lanes_valid;

    logic [31:0] frame;
    int          done_delay, rc_delay;
    logic [15:0] mdl_ml, mdl_bl, mdl_mr, mdl_br;
    logic        mdl_ldl, mdl_ldr;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    hough_pixel_sequencer #(
        .IMG_W(W), .IMG_H(H), .ROI_Y0(Y0), .AW(19), .RD_LAT(2), .RES_LAT(4)
    ) dut (
        .CLK100MHZ(clk), .reset(reset), .start(start), .busy(busy),
        .fb_en(fb_en), .fb_addr(fb_addr), .fb_dout(fb_dout),
        .ht_reset(ht_reset), .ht_reset_complete(ht_reset_complete),
        .ht_x(ht_x), .ht_y(ht_y), .ht_pixel(ht_pixel), .ht_roi(ht_roi),
        .ht_clear(ht_clear), .ht_enable(ht_enable), .ht_done(ht_done),
        .ht_m(ht_m), .ht_b(ht_b), .ht_lane_dep(ht_lane_dep),
        .m_l(m_l), .b_l(b_l), .m_r(m_r), .b_r(b_r), .ld_l(ld_l), .ld_r(ld_r),
        .lanes_valid(lanes_valid)
    );

    logic [116:0] outs;
    assign outs = {busy, fb_en, fb_addr, ht_reset, ht_x, ht_y, ht_pixel, ht_roi, ht_clear,
                   ht_enable, m_l, b_l, m_r, b_r, ld_l, ld_r, lanes_valid};

    // Frame buffer: two-cycle read pipeline.
    logic p1 = 1'b0;
    logic p2 = 1'b0;
    always @(posedge clk) begin
        p1 <= (fb_en && fb_addr < 19'd32) ? frame[fb_addr[4:0]] : 1'b0;
        p2 <= p1;
    end
    assign fb_dout = p2;

    // Hough voter: done after done_delay enabled cycles; clear completes after rc_delay.
    int vcnt = 0;
    int rc_cnt = 0;
    bit rc_busy = 1'b0;
    always @(posedge clk) begin
        if (ht_clear || !ht_enable) begin
            vcnt    <= 0;
            ht_done <= 1'b0;
        end else begin
            vcnt    <= vcnt + 1;
            ht_done <= (vcnt + 1 >= done_delay);
        end
        if (ht_reset) begin
            rc_cnt            <= 0;
            ht_reset_complete <= 1'b0;
            rc_busy           <= 1'b1;
        end else if (rc_busy) begin
            if (rc_cnt >= rc_delay) begin
                ht_reset_complete <= 1'b1;
                rc_busy           <= 1'b0;
            end
            rc_cnt <= rc_cnt + 1;
        end
    end
    assign ht_m        = ht_roi ? mdl_mr : mdl_ml;
    assign ht_b        = ht_roi ? mdl_br : mdl_bl;
    assign ht_lane_dep = ht_roi ? mdl_ldr : mdl_ldl;

    // Protocol monitor: event logs and violation counters.
    int          n_hrst = 0, n_lv = 0, n_viol = 0;
    logic [18:0] rd_q[$];
    logic [25:0] clr_q[$];
    logic        p_en = 1'b0, p_done = 1'b0, p_rst = 1'b1;
    logic [25:0] p_coord = '0;
    always @(negedge clk) begin
        if (ht_reset) n_hrst <= n_hrst + 1;
        if (lanes_valid) n_lv <= n_lv + 1;
        if (fb_en) rd_q.push_back(fb_addr);
        if (ht_clear) clr_q.push_back({ht_roi, ht_pixel, ht_x, ht_y});
        if ((fb_en && !ht_reset_complete) || (ht_clear && ht_enable) ||
            (!p_rst && p_en && !p_done && !ht_enable) ||
            (!p_rst && p_en && p_done && ht_enable) ||
            (!p_rst && p_en && ht_enable && {ht_roi, ht_pixel, ht_x, ht_y} != p_coord))
            n_viol <= n_viol + 1;
        p_en    <= ht_enable;
        p_done  <= ht_done;
        p_rst   <= reset;
        p_coord <= {ht_roi, ht_pixel, ht_x, ht_y};
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rand_results();
        mdl_ml  = 16'($urandom);
        mdl_bl  = 16'($urandom);
        mdl_mr  = 16'($urandom);
        mdl_br  = 16'($urandom);
        mdl_ldl = 1'($urandom);
        mdl_ldr = 1'($urandom);
    endtask

    task automatic run_frame(input string tag, input bit poke);
        logic [18:0] exp_rd[$];
        logic [25:0] exp_clr[$];
        int          b_rd, b_clr, s_hrst, s_lv, s_viol;
        bit          got;
        logic [32:0] cap_l, cap_r;
        for (int r = 0; r < 2; r++)
            for (int y = Y0; y < H; y++)
                for (int x = r * W / 2; x < r * W / 2 + W / 2; x++) begin
                    exp_rd.push_back(19'(y * W + x));
                    if (frame[y * W + x])
                        exp_clr.push_back({1'(r), 1'b1, 12'(x - r * W / 2), 12'(y - Y0)});
                end
        b_rd   = rd_q.size();
        b_clr  = clr_q.size();
        s_hrst = n_hrst;
        s_lv   = n_lv;
        s_viol = n_viol;
        cap_l  = '0;
        cap_r  = '0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        chk({tag, "_busy_on"}, 128'(busy), 128'(1));
        got = 1'b0;
        for (int i = 0; i < 8000 && !got; i++) begin
            @(negedge clk);
            start = (poke && i == 30);
            if (lanes_valid) begin
                got   = 1'b1;
                cap_l = {m_l, b_l, ld_l};
                cap_r = {m_r, b_r, ld_r};
            end
        end
        start = 1'b0;
        chk({tag, "_lanes_valid_seen"}, 128'(got), 128'(1));
        @(negedge clk);
        chk({tag, "_lanes_valid_count"}, 128'(n_lv - s_lv), 128'(1));
        chk({tag, "_ht_reset_count"}, 128'(n_hrst - s_hrst), 128'(2));
        chk({tag, "_read_count"}, 128'(rd_q.size() - b_rd), 128'(exp_rd.size()));
        chk({tag, "_clear_count"}, 128'(clr_q.size() - b_clr), 128'(exp_clr.size()));
        chk({tag, "_protocol_violations"}, 128'(n_viol - s_viol), 128'(0));
        for (int i = 0; i < exp_rd.size(); i++)
            if (b_rd + i < rd_q.size())
                chk({tag, "_read_addr"}, 128'(rd_q[b_rd + i]), 128'(exp_rd[i]));
        for (int i = 0; i < exp_clr.size(); i++)
            if (b_clr + i < clr_q.size())
                chk({tag, "_clear_roi_pix_x_y"}, 128'(clr_q[b_clr + i]), 128'(exp_clr[i]));
        chk({tag, "_left_m_b_ld"}, 128'(cap_l), 128'({mdl_ml, mdl_bl, mdl_ldl}));
        chk({tag, "_right_m_b_ld"}, 128'(cap_r), 128'({mdl_mr, mdl_br, mdl_ldr}));
        repeat (3) @(negedge clk);
        chk({tag, "_busy_off"}, 128'(busy), 128'(0));
    endtask

    initial begin
        bit got;
        int s_hrst;
        reset      = 1'b1;
        start      = 1'b0;
        frame      = '0;
        done_delay = 2;
        rc_delay   = 0;
        rand_results();
        repeat (3) @(negedge clk);
        chk("reset_outputs", 128'(outs), 128'(0));
        @(posedge clk);
        #1 reset = 1'b0;

        frame = '0;
        run_frame("blank", 1'b0);

        frame     = '0;
        frame[29] = 1'b1;
        run_frame("single_5_3", 1'b0);

        rand_results();
        mdl_ml  = 16'h0120;
        mdl_bl  = 16'h0050;
        mdl_ldl = 1'b1;
        frame   = $urandom;
        run_frame("start_while_busy", 1'b1);

        frame      = '0;
        frame[17]  = 1'b1;
        frame[30]  = 1'b1;
        done_delay = 70;
        run_frame("slow_done", 1'b0);

        done_delay = 2;
        rc_delay   = 100;
        frame      = $urandom;
        run_frame("slow_hreset", 1'b0);

        // Abort a scan while voting.
        rc_delay   = 0;
        done_delay = 50;
        frame      = $urandom;
        frame[16]  = 1'b1;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 2000 && !got; i++) begin
            @(negedge clk);
            if (ht_enable) got = 1'b1;
        end
        chk("abort_reached_vote", 128'(got), 128'(1));
        s_hrst = n_hrst;
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_outputs_zero", 128'(outs), 128'(0));
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_idle", 128'({busy, fb_en, ht_enable, ht_clear}), 128'(0));
        chk("abort_no_ht_reset", 128'(n_hrst - s_hrst), 128'(0));
        done_delay = 4;
        rand_results();
        run_frame("after_abort", 1'b0);

        for (int k = 0; k < 4; k++) begin
            frame      = $urandom & $urandom;
            done_delay = $urandom_range(1, 6);
            rc_delay   = $urandom_range(0, 5);
            rand_results();
            run_frame($sformatf("rand%0d", k), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
